// File: rtl/ring_pkg.sv
// Shared definitions for the ring counter decoder: FSM state encoding
// and default widths used by ring_decoder and its one-hot encoder.
package ring_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        ERR    = 2'd2
    } state_t;

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot check and one-hot to binary conversion.
// Ports: word (ring sample in), index (binary bit position), onehot (exactly one bit set).
module ring_onehot_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         word,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     onehot
);

    localparam int IW = $clog2(WIDTH);

    // OR of positions is exact when only one bit is set; the value is
    // meaningless otherwise and is qualified by onehot.
    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (word[i]) begin
                index = index | IW'(i);
            end
        end
    end

    assign onehot = (word != '0) &&
                    ((word & (word - WIDTH'(1))) == '0);

endmodule

// File: rtl/ring_decoder.sv
// Ring counter decoder: tracks a one-hot word that should rotate left by one
// position every clock, locks after LOCK_CNT legal rotations, counts revolutions
// while locked and flags rotation violations.
// Ports: clock, reset (sync, active high), in (ring word); registered outputs
// index, valid, locked, error, rev_count.
// Macro RING_DECODER_STICKY_ERR_EN: when defined a violation parks the FSM in
// ERR (error held until reset); otherwise error pulses for one cycle and the
// decoder returns to HUNT.
module ring_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_CNT = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     valid,
    output logic                     locked,
    output logic                     error,
    output logic [CNT_W-1:0]         rev_count
);

    localparam int SW = $clog2(LOCK_CNT + 1);

    state_t                   state;
    logic [WIDTH-1:0]         prev;
    logic [SW-1:0]            step;
    logic [$clog2(WIDTH)-1:0] enc_index;
    logic                     onehot;
    logic [WIDTH-1:0]         rot;
    logic                     legal;
    logic                     wrap;
    logic [SW-1:0]            step_inc;
    logic                     lock_hit;

    ring_onehot_enc #(
        .WIDTH(WIDTH)
    ) u_enc (
        .word  (in),
        .index (enc_index),
        .onehot(onehot)
    );

    // A one-hot sample equal to the rotated previous sample implies the
    // previous sample was one-hot too.
    assign rot      = {prev[WIDTH-2:0], prev[WIDTH-1]};
    assign legal    = onehot && (in == rot);
    assign wrap     = prev[WIDTH-1];
    assign step_inc = step + SW'(1);
    assign lock_hit = (step_inc == SW'(LOCK_CNT));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= HUNT;
            prev      <= '0;
            step      <= '0;
            index     <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            error     <= 1'b0;
            rev_count <= '0;
        end else begin
            prev  <= in;
            valid <= onehot;
            if (onehot) begin
                index <= enc_index;
            end
            error <= 1'b0;
            unique case (state)
                HUNT: begin
                    if (legal) begin
                        if (lock_hit) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            step      <= '0;
                            rev_count <= '0;
                        end else begin
                            step <= step_inc;
                        end
                    end else begin
                        step <= '0;
                    end
                end
                LOCKED: begin
                    if (legal) begin
                        if (wrap) begin
                            rev_count <= rev_count + CNT_W'(1);
                        end
                    end else begin
                        error  <= 1'b1;
                        locked <= 1'b0;
                        step   <= '0;
`ifdef RING_DECODER_STICKY_ERR_EN
                        state  <= ERR;
`else
                        state  <= HUNT;
`endif
                    end
                end
                ERR: begin
                    error <= 1'b1;
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_decoder.sv
// Randomized scoreboard bench for ring_decoder: a position-based reference
// model queues expected outputs, a monitor pops and compares every cycle.
module tb_ring_decoder;

    localparam int W        = 4;
    localparam int LOCK_CNT = 2;

    typedef struct {
        int valid;
        int idx;
        int locked;
        int err;
        int rev8;
        int rev2;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [1:0] idx_a, idx_b;
    logic       valid_a, valid_b, locked_a, locked_b, err_a, err_b;
    logic [7:0] rev_a;
    logic [1:0] rev_b;

    int total = 0;
    int bad   = 0;
    exp_t q[$];

    int m_valid, m_idx, m_locked, m_err, m_rev, m_streak, m_prev, m_stuck;
    logic [3:0] last;

    ring_decoder #(.WIDTH(4), .CNT_W(8), .LOCK_CNT(LOCK_CNT)) dut (
        .clock(clk), .reset(rst), .in(din), .index(idx_a), .valid(valid_a),
        .locked(locked_a), .error(err_a), .rev_count(rev_a)
    );

    ring_decoder #(.WIDTH(4), .CNT_W(2), .LOCK_CNT(LOCK_CNT)) dut2 (
        .clock(clk), .reset(rst), .in(din), .index(idx_b), .valid(valid_b),
        .locked(locked_b), .error(err_b), .rev_count(rev_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model(input bit r, input logic [3:0] v);
        int  pos;
        bit  legal;
        if (r) begin
            m_valid = 0; m_idx = 0; m_locked = 0; m_err = 0;
            m_rev = 0; m_streak = 0; m_prev = -1; m_stuck = 0;
            return;
        end
        pos = -1;
        if ($countones(v) == 1) begin
            for (int i = 0; i < W; i++) if (v[i]) pos = i;
        end
        legal = (pos >= 0) && (m_prev >= 0) && (pos == (m_prev + 1) % W);
        m_valid = (pos >= 0);
        if (pos >= 0) m_idx = pos;
        if (m_stuck != 0) begin
            m_err = 1;
            m_locked = 0;
        end else if (m_locked != 0) begin
            if (legal) begin
                m_err = 0;
                if (pos == 0) m_rev = m_rev + 1;
            end else begin
                m_err = 1;
                m_locked = 0;
                m_streak = 0;
`ifdef RING_DECODER_STICKY_ERR_EN
                m_stuck = 1;
`endif
            end
        end else begin
            m_err = 0;
            if (legal) begin
                m_streak = m_streak + 1;
                if (m_streak >= LOCK_CNT) begin
                    m_locked = 1;
                    m_rev = 0;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
        end
        m_prev = pos;
    endtask

    task automatic drive(input logic [3:0] v, input bit r);
        exp_t e;
        @(negedge clk);
        rst = r;
        din = v;
        last = v;
        model(r, v);
        e.valid = m_valid; e.idx = m_idx; e.locked = m_locked;
        e.err = m_err; e.rev8 = m_rev % 256; e.rev2 = m_rev % 4;
        q.push_back(e);
    endtask

    task automatic rotate_n(input int n);
        logic [3:0] nx;
        for (int k = 0; k < n; k++) begin
            nx = {last[2:0], last[3]};
            if ($countones(last) != 1) nx = 4'b0001;
            drive(nx, 1'b0);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("valid", int'(valid_a), e.valid);
            chk("index", int'(idx_a), e.idx);
            chk("locked", int'(locked_a), e.locked);
            chk("error", int'(err_a), e.err);
            chk("rev_count", int'(rev_a), e.rev8);
            chk("valid_w2", int'(valid_b), e.valid);
            chk("locked_w2", int'(locked_b), e.locked);
            chk("error_w2", int'(err_b), e.err);
            chk("rev_count_w2", int'(rev_b), e.rev2);
        end
    end

    initial begin
        int r;
        int wait_cnt;
        rst = 1'b1;
        din = 4'b0000;
        last = 4'b0000;
        model(1'b1, 4'b0000);

        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);
        // lock on 0001,0010,0100
        drive(4'b0001, 1'b0);
        drive(4'b0010, 1'b0);
        drive(4'b0100, 1'b0);
        // five revolutions: 5 on 8-bit counter, 1 on 2-bit counter
        rotate_n(20);
        rotate_n(3);
        // hold at 0010 -> violation
        drive(4'b0010, 1'b0);
        drive(4'b0100, 1'b0);
        drive(4'b1000, 1'b0);
        drive(4'b0001, 1'b0);
        // hunt with illegal words
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b0);
        drive(4'b0011, 1'b0);
        drive(4'b0001, 1'b0);
        drive(4'b0010, 1'b0);
        drive(4'b0100, 1'b0);
        drive(4'b1000, 1'b0);
        // reset mid-revolution at rev_count=3
        drive(4'b0000, 1'b1);
        drive(4'b0001, 1'b0);
        drive(4'b0010, 1'b0);
        drive(4'b0100, 1'b0);
        rotate_n(11);
        drive(4'b0100, 1'b1);
        drive(4'b1000, 1'b0);
        drive(4'b0001, 1'b0);
        drive(4'b0010, 1'b0);
        drive(4'b0100, 1'b0);
        // randomized phase
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) drive(4'($urandom_range(0, 15)), 1'b1);
            else if (r < 9) drive(4'($urandom_range(0, 15)), 1'b0);
            else if (r < 12) drive(last, 1'b0);
            else rotate_n(1);
        end

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
